sync_filter: RTL and testbench

Parametrised multi-channel input conditioner. It replaces single D flip-flops on asynchronous pins such as UART RX, buttons and handshake lines.
Each channel passes through an N-stage metastability synchroniser, then a consecutive-sample glitch filter qualified by a sample enable, then rise/fall edge detection.
It sits between the top-level pins and the UART receiver and control logic.

---
 rtl/sync_filter.sv | 78 +++++++
 tb/tb_sync_filter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_filter.sv
// rtl/sync_filter.sv - multi-channel synchroniser, glitch filter and edge detector
module sync_filter #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 2,
    parameter int               FILT_CYCLES = 4,
    parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_sync,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int            CW       = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic [WIDTH-1:0] sync_r [STAGES];
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] q_next;

    // Synchroniser shifts every cycle; en only qualifies the filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_r[s] <= RST_VAL;
            end
        end else begin
            sync_r[0] <= d_in;
            for (int s = 1; s < STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign q_sync = sync_r[STAGES-1];

    always_comb begin
        q_next = q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (en) begin
                if (q_sync[i] == q[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    q_next[i]   = q_sync[i];
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edge pulses are registered alongside q so they line up with its change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= RST_VAL;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            q    <= q_next;
            rise <= q_next & ~q;
            fall <= ~q_next & q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_sync_filter.sv
// tb/tb_sync_filter.sv - self-checking bench for sync_filter
module tb_sync_filter;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       en_a = 1'b1;
    logic       en_b = 1'b1;
    logic [1:0] d_a  = 2'b10;
    logic [3:0] d_b  = 4'b1000;

    logic [1:0] a_qs, a_q, a_r, a_f;
    logic [3:0] b_qs, b_q, b_r, b_f;

    int n_assert = 0;
    int n_fail   = 0;

    sync_filter #(.WIDTH(2), .STAGES(2), .FILT_CYCLES(4), .RST_VAL(2'b10)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .d_in(d_a),
        .q_sync(a_qs), .q(a_q), .rise(a_r), .fall(a_f)
    );

    sync_filter #(.WIDTH(4), .STAGES(3), .FILT_CYCLES(1), .RST_VAL(4'b1000)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .d_in(d_b),
        .q_sync(b_qs), .q(b_q), .rise(b_r), .fall(b_f)
    );

    always #5 clk = ~clk;

    // Reference model: d_in history for the synchroniser, and a window of the
    // most recent enabled samples; q flips once the last FILT_CYCLES samples
    // taken since the previous flip/reset all disagree with it.
    int         mw [2];
    int         ms [2];
    int         mf [2];
    logic [3:0] mrst  [2];
    logic [3:0] mmask [2];
    logic [3:0] m_sh  [2][8];
    logic [3:0] m_win [2][8];
    int         m_since [2][4];
    logic [3:0] m_q [2];
    logic [3:0] m_r [2];
    logic [3:0] m_f [2];

    task automatic model_reset(input int k);
        for (int j = 0; j < 8; j++) m_sh[k][j] = mrst[k];
        for (int i = 0; i < 4; i++) m_since[k][i] = 0;
        m_q[k] = mrst[k];
        m_r[k] = 4'b0;
        m_f[k] = 4'b0;
    endtask

    task automatic model_step(input int k, input logic r, input logic e, input logic [3:0] d);
        logic [3:0] qs;
        logic [3:0] nq;
        logic       all_diff;
        if (r) begin
            model_reset(k);
            return;
        end
        qs = m_sh[k][ms[k]-1];
        nq = m_q[k];
        if (e) begin
            for (int j = 7; j > 0; j--) m_win[k][j] = m_win[k][j-1];
            m_win[k][0] = qs;
            for (int i = 0; i < mw[k]; i++) begin
                m_since[k][i]++;
                if (m_since[k][i] >= mf[k]) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < mf[k]; j++)
                        if (m_win[k][j][i] == m_q[k][i]) all_diff = 1'b0;
                    if (all_diff) begin
                        nq[i] = ~m_q[k][i];
                        m_since[k][i] = 0;
                    end
                end
            end
        end
        m_r[k] = nq & ~m_q[k];
        m_f[k] = ~nq & m_q[k];
        m_q[k] = nq;
        for (int j = 7; j > 0; j--) m_sh[k][j] = m_sh[k][j-1];
        m_sh[k][0] = d & mmask[k];
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step(0, rst, en_a, {2'b00, d_a});
        model_step(1, rst, en_b, d_b);
        check("a_q_sync", {2'b00, a_qs}, m_sh[0][ms[0]-1]);
        check("a_q",      {2'b00, a_q},  m_q[0]);
        check("a_rise",   {2'b00, a_r},  m_r[0]);
        check("a_fall",   {2'b00, a_f},  m_f[0]);
        check("b_q_sync", b_qs, m_sh[1][ms[1]-1]);
        check("b_q",      b_q,  m_q[1]);
        check("b_rise",   b_r,  m_r[1]);
        check("b_fall",   b_f,  m_f[1]);
    endtask

    typedef struct {
        logic       en;
        logic [1:0] d;
        logic [1:0] qs;
        logic [1:0] q;
        logic [1:0] r;
        logic [1:0] f;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input logic en, input logic [1:0] d,
                                input logic [1:0] qs, input logic [1:0] q,
                                input logic [1:0] r, input logic [1:0] f);
        for (int i = 0; i < n; i++) tbl.push_back('{en, d, qs, q, r, f});
    endfunction

    initial begin
        bit seen;
        bit done;
        int nen;

        mw[0] = 2; ms[0] = 2; mf[0] = 4; mrst[0] = 4'b0010; mmask[0] = 4'b0011;
        mw[1] = 4; ms[1] = 3; mf[1] = 1; mrst[1] = 4'b1000; mmask[1] = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            for (int j = 0; j < 8; j++) m_win[k][j] = 4'b0;
        end

        repeat (3) tick();
        check("rst_a_q",      {2'b00, a_q},  4'b0010);
        check("rst_a_q_sync", {2'b00, a_qs}, 4'b0010);
        check("rst_a_edges",  {a_r, a_f},    4'b0000);
        check("rst_b_q",      b_q,           4'b1000);
        rst = 1'b0;

        // fall latency, glitch rejection, rise latency on channel 1
        add(2, 1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00);
        add(1, 1'b1, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00);
        add(4, 1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
        add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        add(2, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        add(1, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
        add(4, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        add(4, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        add(1, 1'b1, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00);
        add(1, 1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00);
        foreach (tbl[i]) begin
            en_a = tbl[i].en;
            d_a  = tbl[i].d;
            tick();
            check("tbl_q_sync", {2'b00, tbl[i].qs}, {2'b00, a_qs});
            check("tbl_q",      {2'b00, a_q},  {2'b00, tbl[i].q});
            check("tbl_rise",   {2'b00, a_r},  {2'b00, tbl[i].r});
            check("tbl_fall",   {2'b00, a_f},  {2'b00, tbl[i].f});
        end

        // enable gated to one cycle in four
        d_a = 2'b00; seen = 1'b0; done = 1'b0; nen = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            en_a = (c % 4 == 3);
            tick();
            if (seen && en_a) nen++;
            if (a_f[1]) begin
                check("gate_samples", 4'(nen), 4'd4);
                done = 1'b1;
            end
            if (a_qs[1] == 1'b0) seen = 1'b1;
        end
        if (!done) begin
            n_assert++;
            n_fail++;
            $display("FAIL gate_timeout: got no fall expected fall within 80 cycles");
        end
        en_a = 1'b1;
        tick();
        check("gate_pulse_width", {2'b00, a_f}, 4'b0000);
        d_a = 2'b10;
        repeat (8) tick();

        // reset two samples into a pending count
        d_a = 2'b01;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("async_rst_q",      {2'b00, a_q},  4'b0010);
        check("async_rst_q_sync", {2'b00, a_qs}, 4'b0010);
        check("async_rst_edges",  {a_r, a_f},    4'b0000);
        model_reset(0);
        model_reset(1);
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 6) begin
                check("rst_hold_q",     {2'b00, a_q}, 4'b0010);
                check("rst_hold_edges", {a_r, a_f},   4'b0000);
            end else begin
                check("rst_done_q",    {2'b00, a_q}, 4'b0001);
                check("rst_done_rise", {2'b00, a_r}, 4'b0001);
                check("rst_done_fall", {2'b00, a_f}, 4'b0010);
            end
        end

        // simultaneous opposite-direction changes, FILT_CYCLES=1
        d_b = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 3) begin
                check("multi_q_before", b_q,  4'b1000);
                check("multi_q_sync",   b_qs, 4'b0001);
            end
            if (i == 4) begin
                check("multi_q",    b_q, 4'b0001);
                check("multi_rise", b_r, 4'b0001);
                check("multi_fall", b_f, 4'b1000);
            end
            if (i == 5) check("multi_edges_clear", b_r | b_f, 4'b0000);
        end

        // randomized run against the model
        for (int c = 0; c < 2000; c++) begin
            if (!rst && $urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                model_reset(0);
                model_reset(1);
            end else begin
                rst = 1'b0;
            end
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 7) == 0) d_a[i] = ~d_a[i];
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) d_b[i] = ~d_b[i];
            en_a = ($urandom_range(0, 3) != 0);
            en_b = ($urandom_range(0, 1) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
